// File: rtl/lcg_stim_gen_if.sv
// lcg_stim_gen_if: valid/ready vector port between the LCG stimulus source and its consumer
interface lcg_stim_gen_if #(parameter int IN_W = 136);
    logic [IN_W-1:0] vec_data;
    logic            vec_valid;
    logic            vec_ready;
    logic [31:0]     vec_idx;
    modport master(output vec_data, vec_valid, vec_idx, input vec_ready);
    modport slave(input vec_data, vec_valid, vec_idx, output vec_ready);
endinterface

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: bit-exact fuzz-harness LCG stream packed into IN_W-bit vectors on a valid/ready port
module lcg_stim_gen #(
    parameter int          IN_W    = 136,
    parameter logic [31:0] LCG_MUL = 32'h41C64E6D,
    parameter logic [31:0] LCG_INC = 32'h3039
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed,
    input  logic [31:0]          num_vectors,
    lcg_stim_gen_if.master       vec,
    output logic                 busy,
    output logic                 done
);
    localparam int NW = (IN_W + 31) / 32;
    localparam int KW = NW > 1 ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     rng_q, rng_d, rem_q, rem_d, idx_q, idx_d, rng_nx;
    logic [IN_W-1:0] data_q, data_d, upd;
    logic [KW-1:0]   k_q, k_d;
    logic            valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    assign rng_nx = rng_q * LCG_MUL + LCG_INC;

    // Each word slot takes the fresh LCG word when selected; the top slot keeps only its low bits.
    for (genvar i = 0; i < NW; i++) begin : g_w
        localparam int HI = (32 * i + 32 > IN_W) ? IN_W : 32 * i + 32;
        assign upd[HI-1:32*i] = (k_q == KW'(i)) ? rng_nx[HI-32*i-1:0] : data_q[HI-1:32*i];
    end

    always_comb begin
        state_d = state_q;
        rng_d   = rng_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        data_d  = data_q;
        k_d     = k_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                rng_d   = seed;
                rem_d   = num_vectors;
                idx_d   = '0;
                k_d     = '0;
                done_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = FILL;
            end
            FILL: begin
                rng_d  = rng_nx;
                data_d = upd;
                k_d    = k_q + 1'b1;
                if (k_q == KW'(NW - 1)) begin
                    k_d     = '0;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: if (vec.vec_ready) begin
                valid_d = 1'b0;
                if (idx_q == rem_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 32'd1;
                    state_d = FILL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rng_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rng_q   <= rng_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec.vec_data  = data_q;
    assign vec.vec_valid = valid_q;
    assign vec.vec_idx   = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: random-handshake bench for lcg_stim_gen against a word-stream LCG reference model
module tb_lcg_stim_gen;
    localparam int IN_W = 136;
    localparam int NW   = (IN_W + 31) / 32;
    localparam logic [31:0] S = 32'd2347132373;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic [31:0] seed, num_vectors;
    int n_chk = 0, n_pass = 0;
    logic [31:0] m_rng, m_idx;
    logic [IN_W-1:0] saved[11];
    logic [IN_W-1:0] last_vec;

    lcg_stim_gen_if #(.IN_W(IN_W)) vec();
    lcg_stim_gen #(.IN_W(IN_W)) dut(.clk(clk), .rst(rst), .start(start), .seed(seed),
        .num_vectors(num_vectors), .vec(vec), .busy(busy), .done(done));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'h41C64E6D + 32'h3039;
    endfunction

    task automatic next_vec(output logic [IN_W-1:0] v);
        logic [32*NW-1:0] w;
        for (int i = 0; i < NW; i++) begin
            m_rng = lcg(m_rng);
            w[32*i +: 32] = m_rng;
        end
        v = w[IN_W-1:0];
    endtask

    task automatic start_run(input logic [31:0] s, input logic [31:0] n);
        @(negedge clk);
        seed = s; num_vectors = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_rng = s; m_idx = 0;
    endtask

    // mode: 0 plain, 1 save first 11 vectors, 2 compare against saved
    task automatic collect(input int nvec, input logic [31:0] n, input int rdy_pct, input bit poke, input int mode);
        int got = 0, cyc = 0;
        bit rdy, hold = 0;
        logic [IN_W-1:0] exp, prev = '0;
        while (got < nvec && cyc < nvec * 40 + 100) begin
            rdy = ($urandom_range(99) < rdy_pct);
            vec.vec_ready = rdy;
            if (hold) begin
                check("valid_hold", vec.vec_valid, 1);
                check("data_stable", vec.vec_data, prev);
            end
            start = poke && busy && !(vec.vec_valid && rdy && vec.vec_idx == n) && $urandom_range(3) == 0;
            seed = $urandom; num_vectors = $urandom;
            if (vec.vec_valid && rdy) begin
                next_vec(exp);
                check("data", vec.vec_data, exp);
                check("idx", vec.vec_idx, m_idx);
                if (mode == 1 && got < 11) saved[got] = exp;
                if (mode == 2 && got < 11) check("vs_saved", vec.vec_data, saved[got]);
                last_vec = vec.vec_data;
                m_idx++;
                got++;
            end
            hold = vec.vec_valid && !rdy;
            prev = vec.vec_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        vec.vec_ready = 1'b0;
        if (got < nvec) check("timeout", got, nvec);
    endtask

    task automatic check_done(input logic [31:0] n);
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("valid_done", vec.vec_valid, 0);
        check("idx_done", vec.vec_idx, n);
    endtask

    initial begin
        int lat, c;
        rst = 1'b0; start = 1'b0; seed = '0; num_vectors = '0; vec.vec_ready = 1'b0;
        #1 rst = 1'b1;
        #20;
        check("rst_valid", vec.vec_valid, 0);
        check("rst_data", vec.vec_data, 0);
        check("rst_idx", vec.vec_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk) rst = 1'b0;

        start_run(0, 0);
        check("busy_fill", busy, 1);
        lat = 0;
        while (!vec.vec_valid && lat < 20) begin @(negedge clk); lat++; end
        check("latency", lat, 5);
        check("w0_seed0", vec.vec_data[31:0], 32'h00003039);
        check("w1_seed0", vec.vec_data[63:32], 32'hD3DC167E);
        collect(1, 0, 100, 0, 0);
        check_done(0);

        start_run(S, 150);
        collect(151, 150, 100, 0, 1);
        check_done(150);

        start_run(S, 10);
        collect(11, 10, 50, 0, 2);
        check_done(10);

        start_run(S, 10);
        collect(3, 10, 100, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", vec.vec_valid, 0);
        check("arst_data", vec.vec_data, 0);
        check("arst_idx", vec.vec_idx, 0);
        check("arst_busy", busy, 0);
        @(negedge clk) rst = 1'b0;
        start_run(S, 0);
        collect(1, 0, 100, 0, 0);
        check("rst_rerun_v0", last_vec, saved[0]);
        check_done(0);

        start_run(S, 20);
        collect(21, 20, 70, 1, 2);
        check_done(20);
        start_run(0, 0);
        collect(1, 0, 100, 0, 0);
        check("restart_w0", last_vec[31:0], 32'h00003039);
        check("restart_w1", last_vec[63:32], 32'hD3DC167E);
        check_done(0);

        start_run(S, 32'hFFFFFFFF);
        collect(1000, 32'hFFFFFFFF, 100, 0, 0);
        check("not_done_big", done, 0);
        c = 0;
        while (!vec.vec_valid && c < 20) begin @(negedge clk); c++; end
        check("valid_before_force", vec.vec_valid, 1);
        force dut.idx_q = 32'hFFFFFFFE;
        @(negedge clk);
        release dut.idx_q;
        m_idx = 32'hFFFFFFFE;
        @(negedge clk);
        check("idx_forced_hold", vec.vec_idx, 32'hFFFFFFFE);
        collect(2, 32'hFFFFFFFF, 100, 0, 0);
        check_done(32'hFFFFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lcg_stim_gen.md
Name: lcg_stim_gen

Overview:
Synthesizable stimulus source that sits directly upstream of the DUT wrapper's flat input bus. It reproduces the fuzz-harness LCG stream bit-exactly: 32-bit LCG, five steps per vector, low word first, last word truncated. Each finished vector is presented on a valid/ready port. Cross-simulator runs and emulation builds therefore see identical input sequences without testbench-side randomisation.

Parameters:
IN_W, 136, width of the produced input vector (in_flat width)
LCG_MUL, 32'h41C64E6D, LCG multiplier
LCG_INC, 32'h3039, LCG increment
NW, derived = ceil(IN_W/32), LCG words per vector (5 at default)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
seed  in  32  initial rng_state, latched on accepted start
num_vectors  in  32  run length N; total vectors emitted = N+1 (initial vector plus N per-cycle vectors)
vec_data  out  IN_W  current vector; stable while vec_valid=1
vec_valid  out  1  vec_data holds a complete vector
vec_ready  in  1  consumer accepts vec_data when vec_valid&vec_ready
vec_idx  out  32  index of the presented vector, 0..N
busy  out  1  high in FILL or PRESENT
done  out  1  high in DONE; sticky until next start or rst

Behaviour:
- Reset (async assert, sync release): state=IDLE; rng_state=0; vec_data=0; vec_valid=0; vec_idx=0; busy=0; done=0; word counter k=0.
- LCG step: rng_state_next = (rng_state*LCG_MUL + LCG_INC) mod 2^32. Keep only the low 32 bits of the product; no wider intermediate leaks.
- States: IDLE, FILL, PRESENT, DONE.
- IDLE: when start=1, latch seed->rng_state and num_vectors->remaining, set k=0, vec_idx=0, done=0, go to FILL.
- FILL: each cycle perform one LCG step. Write the new rng_state to vec_data[32k +: 32] for k<NW-1. For k=NW-1, write only the low IN_W-32(NW-1) bits (8 at default) to the top slice. Increment k. After the step with k=NW-1, go to PRESENT with vec_valid=1 on the following cycle. Latency from accepted start to first vec_valid is NW cycles.
- vec_data bits not yet rewritten in FILL keep their previous-vector values. vec_valid=0 during FILL, so the consumer must not sample them.
- PRESENT: vec_valid=1; hold vec_data, vec_idx and rng_state. On handshake:
  - if vec_idx==N, go to DONE;
  - otherwise vec_idx+=1, k=0, go to FILL.
  - vec_valid drops the cycle after the handshake.
  - Throughput is one vector per NW+1 cycles with vec_ready held high.
- vec_ready is ignored when vec_valid=0. Stalling vec_ready for any number of cycles changes nothing but timing; the sequence is identical.
- DONE: done=1, busy=0, vec_valid=0, vec_data holds the last vector. A start pulse restarts exactly as from IDLE.
- start asserted in FILL or PRESENT is ignored; there is no mid-run restart.
- num_vectors=0: exactly one vector (idx 0) is emitted, then DONE.
- num_vectors=32'hFFFFFFFF: vec_idx reaches 32'hFFFFFFFF, then DONE. There is no wrap; the idx==N compare precedes the increment.
- rst asserted mid-FILL or mid-PRESENT: immediate return to reset values. A partially built vector is discarded, and no handshake is possible in the reset cycle.
- Stream continuity: rng_state is never reseeded between vectors. Vector j word 0 is LCG step 5j+1 from the seed.

Test Plan:
- seed=0, N=0, vec_ready=1:
  - vec_valid rises 5 cycles after start;
  - vec_data[31:0]=32'h00003039, vec_data[63:32]=32'hD3DC167E;
  - one handshake, then done=1, vec_idx=0.
- seed=2347132373, N=150, vec_ready=1: exactly 151 handshakes, vec_idx 0..150. The vector sequence must match the software LCG model, five steps per vector, top word 8 bits. done=1 after the last handshake.
- Same seed, N=10, vec_ready randomly deasserted ~50% of cycles: vec_data stable while valid and not ready, and the accepted sequence is identical to the previous run's first 11 vectors.
- rst pulse during FILL of vector 3, then start with the same seed: outputs return to reset values asynchronously, and the new run's vector 0 equals the original vector 0.
- start pulses during FILL and PRESENT: no effect on sequence or vec_idx. After DONE, start with seed=0 reproduces the first scenario.
- N=32'hFFFFFFFF, with the scoreboard on the first 1000 vectors and force-advancing vec_idx near the top: vec_idx never wraps to 0 and done asserts after idx 32'hFFFFFFFF is accepted.
